// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the CPU datapath and a
// word-addressed data memory with a combinational read bus.
//
// Parameters
//   N    : data/address width (only 32 supported)
//   WAIT : extra memory wait cycles per access (0..15)
//
// Ports
//   clk       : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   req       : request strobe, sampled only while busy=0
//   op        : {store, unsigned, size[1:0]}; size 00=byte 01=half 10=word 11=reserved
//   addr      : byte address
//   wdata     : store data, right-aligned
//   busy      : unit cannot accept a request this cycle
//   done      : one-cycle completion pulse
//   err       : misaligned/reserved flag, valid with done
//   rdata     : load result, valid with done, held until the next done
//   memwrite  : to memory, 0=none 1=word 2=byte 3=half
//   dataadr   : to memory, registered request address
//   writedata : to memory, registered store data
//   readdata  : from memory, combinational read of word dataadr[N-1:2]
module mem_access_unit #(
  parameter int unsigned N    = 32,
  parameter int unsigned WAIT = 0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req,
  input  logic [3:0]   op,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] rdata,
  output logic [1:0]   memwrite,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  input  logic [N-1:0] readdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic       store;
    logic       uns;
    logic [1:0] size;
  } op_t;

  state_t         state_q, state_n;
  logic [CW-1:0]  cnt_q, cnt_n;
  op_t            op_q, op_n, op_in;
  logic [N-1:0]   dataadr_n, writedata_n, rdata_n;
  logic           busy_n, done_n, err_n;
  logic [1:0]     memwrite_n;
  logic           bad_req;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic [N-1:0]   load_val;

  assign op_in = op_t'(op);

  // Reserved size or address not aligned to the access size.
  always_comb begin
    bad_req = 1'b0;
    case (op_in.size)
      2'b01:   bad_req = addr[0];
      2'b10:   bad_req = (addr[1:0] != 2'b00);
      2'b11:   bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  // Big-endian lane select and sign/zero extension of the read word.
  always_comb begin
    byte_sel = 8'h00;
    case (dataadr[1:0])
      2'b00:   byte_sel = readdata[31:24];
      2'b01:   byte_sel = readdata[23:16];
      2'b10:   byte_sel = readdata[15:8];
      default: byte_sel = readdata[7:0];
    endcase
    half_sel = dataadr[1] ? readdata[15:0] : readdata[31:16];
    load_val = readdata;
    case (op_q.size)
      2'b00: load_val = op_q.uns ? {{(N-8){1'b0}}, byte_sel}
                                 : {{(N-8){byte_sel[7]}}, byte_sel};
      2'b01: load_val = op_q.uns ? {{(N-16){1'b0}}, half_sel}
                                 : {{(N-16){half_sel[15]}}, half_sel};
      default: load_val = readdata;
    endcase
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    op_n        = op_q;
    dataadr_n   = dataadr;
    writedata_n = writedata;
    rdata_n     = rdata;
    err_n       = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    memwrite_n  = 2'd0;

    case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        if (req) begin
          op_n        = op_in;
          dataadr_n   = addr;
          writedata_n = wdata;
          if (bad_req) begin
            state_n = DONE;
            err_n   = 1'b1;
            rdata_n = '0;
          end else begin
            state_n = ACCESS;
            cnt_n   = CW'(WAIT);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_n = DONE;
          if (!op_q.store) rdata_n = load_val;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == ACCESS);
    done_n = (state_n == DONE);

    // Single write strobe, in the final ACCESS cycle of a store.
    if ((state_n == ACCESS) && (cnt_n == '0) && op_n.store) begin
      case (op_n.size)
        2'b00:   memwrite_n = 2'd2;
        2'b01:   memwrite_n = 2'd3;
        default: memwrite_n = 2'd1;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dataadr   <= '0;
      writedata <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      memwrite  <= 2'd0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      op_q      <= op_n;
      dataadr   <= dataadr_n;
      writedata <= writedata_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      memwrite  <= memwrite_n;
    end
  end

endmodule
